// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add arbiter.
// Default width, FSM state encoding and a counter-width helper.
package serial_add_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// Single full-adder slice used by the serial add datapath.
// Pure combinational sum and majority carry.
module full_adder_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_add_arb.sv
// Round-robin two-requester front end for a bit-serial adder.
// Define SERIAL_ADD_OVF_EN to add the signed overflow output rsp_ovf.
module serial_add_arb
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             rsp_ovf
`endif
);

  localparam int CW = clog2(WIDTH);

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             ovf_q, ovf_d;
  logic             g0, g1;
  logic             fa_s, fa_co;

  full_adder_1bit u_fa (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .c_i  (cy_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // rr_q names the winner only when both requesters are valid
  assign g1 = req1_valid & (~req0_valid | rr_q);
  assign g0 = req0_valid & ~g1;

  assign req0_ready = (state_q == IDLE) & ~rst & g0;
  assign req1_ready = (state_q == IDLE) & ~rst & g1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (g0 | g1) begin
          a_d     = g1 ? req1_a : req0_a;
          b_d     = g1 ? req1_b : req0_b;
          cy_d    = 1'b0;
          cnt_d   = '0;
          id_d    = g1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        cy_d  = fa_co;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        sum_d = {fa_s, sum_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          ovf_d   = cy_q ^ fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rr_d    = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cy_q;
  assign rsp_id    = id_q;

`ifdef SERIAL_ADD_OVF_EN
  assign rsp_ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_arb.sv
// Randomized bench for serial_add_arb at WIDTH 8, 4 and 16.
// Results are compared against plain-arithmetic sums and a round-robin model.
module tb_serial_add_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rrdy;
  logic [15:0] a0, b0, a1, b1;
  int          sel;

  always #5 clk = ~clk;

  logic       r0_8, r1_8, rv_8, rc_8, ri_8, bz_8;
  logic [7:0] rs_8;
  logic       r0_4, r1_4, rv_4, rc_4, ri_4, bz_4;
  logic [3:0] rs_4;
  logic        r0_16, r1_16, rv_16, rc_16, ri_16, bz_16;
  logic [15:0] rs_16;
`ifdef SERIAL_ADD_OVF_EN
  logic ov_8, ov_4, ov_16;
`endif

  serial_add_arb #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .req0_valid(v0 && sel == 0), .req0_ready(r0_8),
    .req0_a(a0[7:0]), .req0_b(b0[7:0]),
    .req1_valid(v1 && sel == 0), .req1_ready(r1_8),
    .req1_a(a1[7:0]), .req1_b(b1[7:0]),
    .rsp_valid(rv_8), .rsp_ready(rrdy && sel == 0),
    .rsp_sum(rs_8), .rsp_cout(rc_8), .rsp_id(ri_8), .busy(bz_8)
`ifdef SERIAL_ADD_OVF_EN
    , .rsp_ovf(ov_8)
`endif
  );

  serial_add_arb #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(v0 && sel == 1), .req0_ready(r0_4),
    .req0_a(a0[3:0]), .req0_b(b0[3:0]),
    .req1_valid(v1 && sel == 1), .req1_ready(r1_4),
    .req1_a(a1[3:0]), .req1_b(b1[3:0]),
    .rsp_valid(rv_4), .rsp_ready(rrdy && sel == 1),
    .rsp_sum(rs_4), .rsp_cout(rc_4), .rsp_id(ri_4), .busy(bz_4)
`ifdef SERIAL_ADD_OVF_EN
    , .rsp_ovf(ov_4)
`endif
  );

  serial_add_arb #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .req0_valid(v0 && sel == 2), .req0_ready(r0_16),
    .req0_a(a0), .req0_b(b0),
    .req1_valid(v1 && sel == 2), .req1_ready(r1_16),
    .req1_a(a1), .req1_b(b1),
    .rsp_valid(rv_16), .rsp_ready(rrdy && sel == 2),
    .rsp_sum(rs_16), .rsp_cout(rc_16), .rsp_id(ri_16), .busy(bz_16)
`ifdef SERIAL_ADD_OVF_EN
    , .rsp_ovf(ov_16)
`endif
  );

  logic        c_r0, c_r1, c_rv, c_rc, c_ri, c_bz, c_ov;
  logic [15:0] c_rs;

  always_comb begin
    c_r0 = r0_8; c_r1 = r1_8; c_rv = rv_8;
    c_rc = rc_8; c_ri = ri_8; c_bz = bz_8;
    c_rs = {8'h00, rs_8};
    c_ov = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    c_ov = ov_8;
`endif
    if (sel == 1) begin
      c_r0 = r0_4; c_r1 = r1_4; c_rv = rv_4;
      c_rc = rc_4; c_ri = ri_4; c_bz = bz_4;
      c_rs = {12'h000, rs_4};
`ifdef SERIAL_ADD_OVF_EN
      c_ov = ov_4;
`endif
    end else if (sel == 2) begin
      c_r0 = r0_16; c_r1 = r1_16; c_rv = rv_16;
      c_rc = rc_16; c_ri = ri_16; c_bz = bz_16;
      c_rs = rs_16;
`ifdef SERIAL_ADD_OVF_EN
      c_ov = ov_16;
`endif
    end
  end

  int checks;
  int errors;
  bit rr[3];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int wid(input int s);
    return (s == 1) ? 4 : (s == 2) ? 16 : 8;
  endfunction

  // Called at a negedge with requester inputs already driven.
  task automatic serve(input int hold);
    int          w, lat, mask;
    bit          win, ecout, eovf;
    logic [16:0] full;
    logic [15:0] ea, eb, esum;
    #1;
    w    = wid(sel);
    mask = (1 << w) - 1;
    win  = (v0 && v1) ? rr[sel] : v1;
    check("ready0", c_r0, (win == 1'b0));
    check("ready1", c_r1, (win == 1'b1));
    ea    = (win ? a1 : a0) & mask[15:0];
    eb    = (win ? b1 : b0) & mask[15:0];
    full  = {1'b0, ea} + {1'b0, eb};
    esum  = full[15:0] & mask[15:0];
    ecout = full[w];
    eovf  = (ea[w-1] == eb[w-1]) && (esum[w-1] != ea[w-1]);
    @(posedge clk);
    @(negedge clk);
    if (win) v1 = 1'b0;
    else v0 = 1'b0;
    lat = 0;
    while (!c_rv && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, w);
    check("sum", c_rs, esum);
    check("cout", c_rc, ecout);
    check("id", c_ri, win);
    check("busy_done", c_bz, 1);
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", c_ov, eovf);
`endif
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", c_rv, 1);
      check("hold_sum", c_rs, esum);
      check("hold_cout", c_rc, ecout);
      check("hold_ready", {c_r0, c_r1}, 0);
      check("hold_busy", c_bz, 1);
    end
    rrdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rrdy = 1'b0;
    check("released", c_rv, 0);
    check("idle", c_bz, 0);
    rr[sel] = !win;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    sel    = 0;
    rst    = 1'b1;
    v0     = 1'b0;
    v1     = 1'b0;
    rrdy   = 1'b0;
    a0 = 16'h0; b0 = 16'h0; a1 = 16'h0; b1 = 16'h0;
    rr[0] = 0; rr[1] = 0; rr[2] = 0;

    @(negedge clk);
    v0 = 1'b1;
    v1 = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_ready", {c_r0, c_r1}, 0);
      check("rst_valid", c_rv, 0);
      check("rst_busy", c_bz, 0);
      check("rst_rsp", {c_rs, c_rc, c_ri}, 0);
    end
    sel = 0;

    @(negedge clk);
    rst = 1'b0;
    a0 = 16'h03; b0 = 16'h04; a1 = 16'h05; b1 = 16'h06;
    serve(0);
    serve(0);
    v0 = 1'b1; v1 = 1'b1;
    a0 = 16'($urandom); b0 = 16'($urandom);
    a1 = 16'($urandom); b1 = 16'($urandom);
    serve(0);
    serve(0);

    v0 = 1'b1; a0 = 16'h01; b0 = 16'h02;
    serve(5);
    v1 = 1'b1; a1 = 16'hFF; b1 = 16'h01;
    serve(0);
    v0 = 1'b1; a0 = 16'h7F; b0 = 16'h01;
    serve(1);

    v0 = 1'b1; a0 = 16'h55; b0 = 16'h66;
    #1;
    check("mid_accept", c_r0, 1);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    v0 = 1'b1;
    v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", c_rv, 0);
    check("mid_rst_busy", c_bz, 0);
    check("mid_rst_rsp", {c_rs, c_rc, c_ri}, 0);
    check("mid_rst_ready", {c_r0, c_r1}, 0);
    rr[0] = 0; rr[1] = 0; rr[2] = 0;
    rst = 1'b0;
    a0 = 16'h10; b0 = 16'h20;
    a1 = 16'($urandom); b1 = 16'($urandom);
    serve(0);
    serve(0);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      v0 = 1'b1; a0 = 16'hFFFF; b0 = 16'hFFFF;
      v1 = 1'b0;
      serve(0);
      for (int n = 0; n < 20; n++) begin
        if (!v0 && ($urandom % 2) == 0) begin
          v0 = 1'b1; a0 = 16'($urandom); b0 = 16'($urandom);
        end
        if (!v1 && ($urandom % 2) == 0) begin
          v1 = 1'b1; a1 = 16'($urandom); b1 = 16'($urandom);
        end
        if (!v0 && !v1) begin
          v0 = 1'b1; a0 = 16'($urandom); b0 = 16'($urandom);
        end
        serve(int'($urandom % 3));
      end
      v0 = 1'b0;
      v1 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
